pipeline_hazard_tracker: RTL and testbench

//  Producer side of EX-stage operand forwarding in the 5-stage RV32 pipeline.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/fwd_match.sv | 19 +
 rtl/pipeline_hazard_tracker.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_tracker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EX-stage forwarding/hazard tracker: forward-select codes
// and the per-stage shadow slot describing an in-flight instruction.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } hz_slot_t;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/fwd_match.sv
// Does a shadowed producer slot write the given (used) source register?
// x0 is never a producer.
module fwd_match
    import pipe_pkg::*;
(
    input  hz_slot_t             slot,
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 rs_used,
    output logic                 hit
);

    logic unused_mem_read;

    assign unused_mem_read = slot.mem_read;

    assign hit = slot.valid & slot.reg_write & (slot.rd != REG_ZERO)
               & (slot.rd == rs) & rs_used;

endmodule

// File: rtl/pipeline_hazard_tracker.sv
// Shadows EX/MEM/WB destination info, registers EX operand forward selects into
// ID/EX, raises the load-use stall and counts the bubbles it inserts.
module pipeline_hazard_tracker
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_IDX_W,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      mem_stall,
    input  logic                      branch_flush,
    output logic [1:0]                fwd_sel_op1,
    output logic [1:0]                fwd_sel_op2,
    output logic                      id_stall,
    output logic                      ex_bubble,
    output logic [CNT_WIDTH-1:0]      bubble_count
);

    hz_slot_t ex_slot;
    hz_slot_t mem_slot;
    hz_slot_t wb_slot;
    hz_slot_t id_slot;

    fwd_sel_e sel_op1;
    fwd_sel_e sel_op2;
    fwd_sel_e sel_op1_next;
    fwd_sel_e sel_op2_next;

    logic ex_hit1;
    logic ex_hit2;
    logic mem_hit1;
    logic mem_hit2;
    logic load_use;
    logic unused_wb_slot;

    // WB conflicts are resolved by the write-first register file, so the WB
    // shadow is kept for completeness but feeds no select.
    assign unused_wb_slot = ^wb_slot;

    fwd_match u_ex_rs1  (.slot(ex_slot),  .rs(id_rs1), .rs_used(id_rs1_used), .hit(ex_hit1));
    fwd_match u_ex_rs2  (.slot(ex_slot),  .rs(id_rs2), .rs_used(id_rs2_used), .hit(ex_hit2));
    fwd_match u_mem_rs1 (.slot(mem_slot), .rs(id_rs1), .rs_used(id_rs1_used), .hit(mem_hit1));
    fwd_match u_mem_rs2 (.slot(mem_slot), .rs(id_rs2), .rs_used(id_rs2_used), .hit(mem_hit2));

    always_comb begin
        id_slot           = '0;
        id_slot.valid     = id_valid;
        id_slot.rd        = id_rd;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
    end

    // A load in EX cannot forward yet; its data exists only once it reaches MEM.
    always_comb begin
        load_use = id_valid & ex_slot.valid & ex_slot.mem_read & (ex_slot.rd != REG_ZERO)
                 & ((id_rs1_used & (ex_slot.rd == id_rs1))
                  | (id_rs2_used & (ex_slot.rd == id_rs2)));
    end

    always_comb begin
        sel_op1_next = FWD_RF;
        sel_op2_next = FWD_RF;
        if (ex_hit1) begin
            sel_op1_next = FWD_EXMEM;
        end else if (mem_hit1) begin
            sel_op1_next = FWD_MEMWB;
        end
        if (ex_hit2) begin
            sel_op2_next = FWD_EXMEM;
        end else if (mem_hit2) begin
            sel_op2_next = FWD_MEMWB;
        end
    end

    assign id_stall  = mem_stall | (~branch_flush & load_use);
    assign ex_bubble = ~mem_stall & (branch_flush | load_use);

    // mem_stall freezes everything; flush and load-use both drop a bubble into
    // EX, but only load-use bubbles are counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_slot      <= '0;
            mem_slot     <= '0;
            wb_slot      <= '0;
            sel_op1      <= FWD_RF;
            sel_op2      <= FWD_RF;
            bubble_count <= '0;
        end else if (!mem_stall) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (branch_flush || load_use) begin
                ex_slot <= '0;
                sel_op1 <= FWD_RF;
                sel_op2 <= FWD_RF;
                if (!branch_flush) begin
                    bubble_count <= bubble_count + CNT_WIDTH'(1);
                end
            end else begin
                ex_slot <= id_slot;
                sel_op1 <= sel_op1_next;
                sel_op2 <= sel_op2_next;
            end
        end
    end

    assign fwd_sel_op1 = sel_op1;
    assign fwd_sel_op2 = sel_op2;

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences, then random traffic against an in-flight instruction model.
module tb_pipeline_hazard_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        mem_stall;
    logic        branch_flush;
    logic [1:0]  fwd_sel_op1;
    logic [1:0]  fwd_sel_op2;
    logic        id_stall;
    logic        ex_bubble;
    logic [31:0] bubble_count;

    pipeline_hazard_tracker dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_stall(mem_stall), .branch_flush(branch_flush),
        .fwd_sel_op1(fwd_sel_op1), .fwd_sel_op2(fwd_sel_op2),
        .id_stall(id_stall), .ex_bubble(ex_bubble), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n, vld;
        int rs1, rs2;
        bit u1, u2;
        int rd;
        bit rw, mr, ms, bf;
        bit e_stall, e_bub;
        int e_f1, e_f2;
        longint e_cnt;
    } vec_t;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } instr_t;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit vld, int rs1, int rs2, bit u1, bit u2, int rd,
                                bit rw, bit mr, bit ms, bit bf,
                                bit es, bit eb, int f1, int f2, longint cnt);
        vec_t v;
        v.rst_n = r; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.mr = mr; v.ms = ms; v.bf = bf;
        v.e_stall = es; v.e_bub = eb; v.e_f1 = f1; v.e_f2 = f2; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n        = v.rst_n;
        id_valid     = v.vld;
        id_rs1       = 5'(v.rs1);
        id_rs2       = 5'(v.rs2);
        id_rs1_used  = v.u1;
        id_rs2_used  = v.u2;
        id_rd        = 5'(v.rd);
        id_reg_write = v.rw;
        id_mem_read  = v.mr;
        mem_stall    = v.ms;
        branch_flush = v.bf;
    endtask

    // Drive one cycle, check combinational outputs before the edge and
    // registered outputs just after it.
    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check_output({tag, "_id_stall"}, longint'(id_stall), longint'(v.e_stall));
        check_output({tag, "_ex_bubble"}, longint'(ex_bubble), longint'(v.e_bub));
        @(posedge clk);
        #1;
        check_output({tag, "_fwd1"}, longint'(fwd_sel_op1), longint'(v.e_f1));
        check_output({tag, "_fwd2"}, longint'(fwd_sel_op2), longint'(v.e_f2));
        check_output({tag, "_count"}, longint'(bubble_count), v.e_cnt);
    endtask

    function automatic bit produces(instr_t i, int r);
        return i.v && i.rw && i.rd != 0 && i.rd == r;
    endfunction

    function automatic int pick_sel(instr_t ex, instr_t mem, int r, bit used);
        if (!used) return 0;
        if (produces(ex, r)) return 1;
        if (produces(mem, r)) return 2;
        return 0;
    endfunction

    initial begin
        // reset, then spec scenarios 1-4 and 6, plus unused-operand,
        // EX-over-MEM priority and non-writing producer cases
        tbl.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 1,2, 1,1, 5, 1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 5,1, 1,1, 6, 1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1,1, 1,2, 1,1, 5, 1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 1,5, 1,1, 7, 1,0,0,0, 0,0,0,2,0));
        tbl.push_back(mk(1,1, 1,0, 1,0, 5, 1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 5,5, 1,1, 6, 1,0,0,0, 1,1,0,0,1));
        tbl.push_back(mk(1,1, 5,5, 1,1, 6, 1,0,0,0, 0,0,2,2,1));
        tbl.push_back(mk(1,1, 1,0, 1,0, 0, 1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1, 0,0, 1,1, 6, 1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1, 1,0, 1,0, 0, 1,1,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1, 0,0, 1,1, 7, 1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1, 1,2, 1,1, 5, 1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1, 5,5, 1,1, 6, 1,0,0,1, 0,1,0,0,1));
        tbl.push_back(mk(1,1, 6,5, 1,1, 8, 1,0,0,0, 0,0,0,2,1));
        tbl.push_back(mk(1,1, 1,0, 1,0, 9, 1,1,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1, 9,0, 1,1,10, 1,0,0,1, 0,1,0,0,1));
        tbl.push_back(mk(1,1, 9,9, 1,0,11, 1,0,0,0, 0,0,2,0,1));
        tbl.push_back(mk(1,1,11,1, 1,1,11, 1,0,0,0, 0,0,1,0,1));
        tbl.push_back(mk(1,1,11,11,1,1,12, 1,0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(1,1,12,1, 1,1,13, 0,0,0,0, 0,0,1,0,1));
        tbl.push_back(mk(1,1,13,13,1,1,14, 1,0,0,0, 0,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // load in EX frozen by a 3-cycle bus stall (flush held meanwhile is ignored)
        apply_stimulus(mk(1,0, 0,0, 0,0, 0, 0,0,0,0, 0,0,0,0,1), "ms_nop0");
        apply_stimulus(mk(1,0, 0,0, 0,0, 0, 0,0,0,0, 0,0,0,0,1), "ms_nop1");
        apply_stimulus(mk(1,1, 1,2, 1,1, 3, 1,0,0,0, 0,0,0,0,1), "ms_add3");
        apply_stimulus(mk(1,1, 3,0, 1,0, 5, 1,1,0,0, 0,0,1,0,1), "ms_lw5");
        apply_stimulus(mk(1,1, 5,1, 1,1, 6, 1,0,1,0, 1,0,1,0,1), "ms_hold0");
        apply_stimulus(mk(1,1, 5,1, 1,1, 6, 1,0,1,1, 1,0,1,0,1), "ms_hold1");
        apply_stimulus(mk(1,1, 5,1, 1,1, 6, 1,0,1,0, 1,0,1,0,1), "ms_hold2");
        apply_stimulus(mk(1,1, 5,1, 1,1, 6, 1,0,0,0, 1,1,0,0,2), "ms_bubble");
        apply_stimulus(mk(1,1, 5,1, 1,1, 6, 1,0,0,0, 0,0,2,0,2), "ms_reissue");

        // reset asserted while a load-use stall is pending
        apply_stimulus(mk(1,1, 6,0, 1,0, 5, 1,1,0,0, 0,0,1,0,2), "rst_lw");
        apply_stimulus(mk(0,1, 5,5, 1,1, 7, 1,0,0,0, 1,1,0,0,0), "rst_mid");
        apply_stimulus(mk(1,1, 5,5, 1,1, 7, 1,0,0,0, 0,0,0,0,0), "rst_after");

        // random traffic against an in-flight instruction model
        begin
            instr_t ex_i, mem_i, nw;
            int     m_f1, m_f2;
            longint m_cnt;
            bit     lu, e_stall, e_bub;
            vec_t   v;
            ex_i = '{0, 0, 0, 0};
            mem_i = '{0, 0, 0, 0};
            m_f1 = 0; m_f2 = 0; m_cnt = 0;
            for (int c = 0; c < 600; c++) begin
                v.rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
                v.vld   = ($urandom_range(0, 9) != 0);
                v.rs1   = int'($urandom_range(0, 7));
                v.rs2   = int'($urandom_range(0, 7));
                v.u1    = ($urandom_range(0, 4) != 0);
                v.u2    = ($urandom_range(0, 2) != 0);
                v.rd    = int'($urandom_range(0, 7));
                v.rw    = ($urandom_range(0, 4) != 0);
                v.mr    = ($urandom_range(0, 2) == 0);
                v.ms    = ($urandom_range(0, 6) == 0);
                v.bf    = ($urandom_range(0, 9) == 0);
                @(negedge clk);
                drive(v);
                lu = v.vld && ex_i.v && ex_i.ld && ex_i.rd != 0 &&
                     ((v.u1 && ex_i.rd == v.rs1) || (v.u2 && ex_i.rd == v.rs2));
                e_stall = v.ms || (!v.bf && lu);
                e_bub   = !v.ms && (v.bf || lu);
                #1;
                check_output($sformatf("rnd%0d_id_stall", c), longint'(id_stall), longint'(e_stall));
                check_output($sformatf("rnd%0d_ex_bubble", c), longint'(ex_bubble), longint'(e_bub));
                if (!v.rst_n) begin
                    ex_i = '{0, 0, 0, 0};
                    mem_i = '{0, 0, 0, 0};
                    m_f1 = 0; m_f2 = 0; m_cnt = 0;
                end else if (!v.ms) begin
                    if (v.bf || lu) begin
                        nw = '{0, 0, 0, 0};
                        m_f1 = 0; m_f2 = 0;
                        if (!v.bf) m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
                    end else begin
                        nw = '{v.vld, v.rd, v.rw, v.mr};
                        m_f1 = pick_sel(ex_i, mem_i, v.rs1, v.u1);
                        m_f2 = pick_sel(ex_i, mem_i, v.rs2, v.u2);
                    end
                    mem_i = ex_i;
                    ex_i  = nw;
                end
                @(posedge clk);
                #1;
                check_output($sformatf("rnd%0d_fwd1", c), longint'(fwd_sel_op1), longint'(m_f1));
                check_output($sformatf("rnd%0d_fwd2", c), longint'(fwd_sel_op2), longint'(m_f2));
                check_output($sformatf("rnd%0d_count", c), longint'(bubble_count), m_cnt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
